// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: recovers raster position from sampled HS/VS, locks onto the
// line/frame timing, counts matching pixels and probes one pixel per frame.
// Define VGA_RX_CRC_EN to add a CRC-16-CCITT over visible pixels per frame.
module vga_rx_monitor #(
    parameter int         H_ACTIVE     = 640,
    parameter int         H_TOTAL      = 800,
    parameter int         HS_TO_ACTIVE = 144,
    parameter int         V_ACTIVE     = 480,
    parameter int         V_TOTAL      = 525,
    parameter int         VS_TO_ACTIVE = 34,
    parameter logic [7:0] MATCH_COLOR  = 8'hE0,
    parameter int         PROBE_X      = 320,
    parameter int         PROBE_Y      = 240,
    parameter int         LOCK_FRAMES  = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    input  logic [7:0]  i_rgb,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_active,
    output logic        o_locked,
    output logic        o_frame_stb,
    output logic        o_err,
    output logic [18:0] o_match_count,
    output logic [7:0]  o_probe_color,
    output logic [15:0] o_frame_crc
);
    localparam logic [9:0]  HA_LO  = 10'(HS_TO_ACTIVE);
    localparam logic [9:0]  HA_HI  = 10'(HS_TO_ACTIVE + H_ACTIVE);
    localparam logic [9:0]  VA_LO  = 10'(VS_TO_ACTIVE);
    localparam logic [9:0]  VA_HI  = 10'(VS_TO_ACTIVE + V_ACTIVE);
    localparam logic [8:0]  VA_LO9 = 9'(VS_TO_ACTIVE);
    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [9:0]  V_TOT  = 10'(V_TOTAL);
    localparam logic [9:0]  P_X    = 10'(PROBE_X);
    localparam logic [8:0]  P_Y    = 9'(PROBE_Y);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  good_q, good_d;
    logic        hs_q, vs_q;
    logic [9:0]  hcnt_q, vcnt_q, lcnt_q;
    logic        vs_pend_q, first_q, bad_q;
    logic [18:0] acc_q;

    logic        hs_edge, vs_edge;
    logic [9:0]  hpos, vpos;
    logic [9:0]  x_now;
    logic [8:0]  y_now;
    logic        line_bad, frame_bad, err_now;
    logic        act_now, match_now, probe_hit;

    assign hs_edge = i_pix_stb & hs_q & ~i_hs;
    assign vs_edge = i_pix_stb & vs_q & ~i_vs;
    assign o_locked = (state_q == LOCKED);

    // position of the pixel on the current strobe and timing checks
    always_comb begin
        hpos = (hcnt_q == 10'h3FF) ? hcnt_q : hcnt_q + 10'd1;
        vpos = vcnt_q;
        if (hs_edge) begin
            hpos = 10'd0;
            if (vs_edge | vs_pend_q)
                vpos = 10'd0;
            else if (vcnt_q != 10'h3FF)
                vpos = vcnt_q + 10'd1;
        end
        x_now     = hpos - HA_LO;
        y_now     = vpos[8:0] - VA_LO9;
        line_bad  = hs_edge & ~first_q &
                    (({1'b0, hcnt_q} + 11'd1) != H_TOT);
        frame_bad = vs_edge & ((lcnt_q != V_TOT) | bad_q | line_bad);
        err_now   = (state_q == LOCKED) & (line_bad | frame_bad);
        act_now   = (state_q == LOCKED) &
                    (hpos >= HA_LO) & (hpos < HA_HI) &
                    (vpos >= VA_LO) & (vpos < VA_HI);
        match_now = act_now & (i_rgb == MATCH_COLOR);
        probe_hit = act_now & (x_now == P_X) & (y_now == P_Y);
    end

    // lock state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= SEARCH;
            good_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    // lock state transitions and good-frame counting
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        unique case (state_q)
            SEARCH: begin
                if (vs_edge) begin
                    state_d = MEASURE;
                    good_d  = 8'd0;
                end
            end
            MEASURE: begin
                if (vs_edge) begin
                    if (frame_bad) begin
                        good_d = 8'd0;
                    end else if (good_q + 8'd1 >= LOCK_N) begin
                        state_d = LOCKED;
                        good_d  = 8'd0;
                    end else begin
                        good_d = good_q + 8'd1;
                    end
                end else if (line_bad) begin
                    good_d = 8'd0;
                end
            end
            LOCKED: begin
                if (line_bad | frame_bad)
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    // counters, sync history, pixel outputs and per-frame results
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            hcnt_q        <= 10'd0;
            vcnt_q        <= 10'd0;
            lcnt_q        <= 10'd0;
            vs_pend_q     <= 1'b0;
            first_q       <= 1'b0;
            bad_q         <= 1'b0;
            acc_q         <= 19'd0;
            o_x           <= 10'd0;
            o_y           <= 9'd0;
            o_active      <= 1'b0;
            o_frame_stb   <= 1'b0;
            o_err         <= 1'b0;
            o_match_count <= 19'd0;
            o_probe_color <= 8'd0;
        end else begin
            o_frame_stb <= 1'b0;
            o_err       <= 1'b0;
            if (i_pix_stb) begin
                hs_q     <= i_hs;
                vs_q     <= i_vs;
                hcnt_q   <= hpos;
                vcnt_q   <= vpos;
                o_active <= act_now;
                o_x      <= act_now ? x_now : 10'd0;
                o_y      <= act_now ? y_now : 9'd0;
                o_err    <= err_now;
                if (vs_edge)
                    vs_pend_q <= ~hs_edge;
                else if (hs_edge)
                    vs_pend_q <= 1'b0;
                if (vs_edge)
                    lcnt_q <= {9'd0, hs_edge};
                else if (hs_edge && lcnt_q != 10'h3FF)
                    lcnt_q <= lcnt_q + 10'd1;
                if (vs_edge && state_q == SEARCH)
                    first_q <= 1'b1;
                else if (hs_edge)
                    first_q <= 1'b0;
                if (vs_edge)
                    bad_q <= 1'b0;
                else if (line_bad)
                    bad_q <= 1'b1;
                if (probe_hit)
                    o_probe_color <= i_rgb;
                if (err_now) begin
                    acc_q <= 19'd0;
                end else if (vs_edge) begin
                    acc_q <= 19'd0;
                    if (state_q == LOCKED) begin
                        o_match_count <= acc_q + {18'd0, match_now};
                        o_frame_stb   <= 1'b1;
                    end
                end else if (match_now) begin
                    acc_q <= acc_q + 19'd1;
                end
            end
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_now;

    function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                             input logic [7:0]  d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++)
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        return r;
    endfunction

    assign crc_now = act_now ? crc_byte(crc_q, i_rgb) : crc_q;

    // running CRC of visible bytes, latched alongside the frame strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc_q       <= 16'hFFFF;
            o_frame_crc <= 16'h0000;
        end else if (i_pix_stb) begin
            if (err_now) begin
                crc_q <= 16'hFFFF;
            end else if (vs_edge) begin
                crc_q <= 16'hFFFF;
                if (state_q == LOCKED)
                    o_frame_crc <= crc_now;
            end else begin
                crc_q <= crc_now;
            end
        end
    end
`else
    assign o_frame_crc = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor: drives a scaled-down VGA raster (24x14 total, 16x8
// visible) and scoreboards per-frame results against a bench-side model.
module tb_vga_rx_monitor;
    localparam int HA  = 16;
    localparam int HT  = 24;
    localparam int HSS = 18;
    localparam int HSE = 22;
    localparam int VA  = 8;
    localparam int VT  = 14;
    localparam int VSS = 9;
    localparam int VSE = 11;
    localparam int PX  = 5;
    localparam int PY  = 3;

    logic        clk = 1'b0;
    logic        rst, stb, hs, vs;
    logic [7:0]  rgb;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_active, o_locked, o_frame_stb, o_err;
    logic [18:0] o_match_count;
    logic [7:0]  o_probe_color;
    logic [15:0] o_frame_crc;

    int checks  = 0;
    int errors  = 0;
    int err_seen = 0;
    int err_exp  = 0;

    typedef struct packed {
        logic [18:0] cnt;
        logic [15:0] crc;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_TO_ACTIVE(HT - HSS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_TO_ACTIVE(VT - VSS - 1),
        .MATCH_COLOR(8'hE0), .PROBE_X(PX), .PROBE_Y(PY),
        .LOCK_FRAMES(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_stb(stb),
        .i_hs(hs), .i_vs(vs), .i_rgb(rgb),
        .o_x(o_x), .o_y(o_y), .o_active(o_active),
        .o_locked(o_locked), .o_frame_stb(o_frame_stb),
        .o_err(o_err), .o_match_count(o_match_count),
        .o_probe_color(o_probe_color), .o_frame_crc(o_frame_crc)
    );

    function automatic logic [15:0] crc_ref(input logic [15:0] c,
                                            input logic [7:0]  d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    function automatic logic [7:0] non_e0();
        logic [7:0] v;
        v = 8'($urandom);
        return (v == 8'hE0) ? 8'hE1 : v;
    endfunction

    function automatic logic [7:0] pick(input int mode, input int x,
                                        input int y);
        if (!(x < HA && y < VA))
            return 8'($urandom);
        case (mode)
            1: return (y * HA + x < 100) ? 8'hE0 : non_e0();
            2: return (x == PX && y == PY) ? 8'h1C : 8'h00;
            3: return ($urandom_range(0, 3) == 0) ? 8'hE0 : non_e0();
            default: return 8'h00;
        endcase
    endfunction

    // frame-result scoreboard and o_err pulse counter
    always @(posedge clk) begin : mon
        exp_t e;
        #1;
        if (o_err === 1'b1)
            err_seen++;
        if (o_frame_stb === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL frame_stb_unexpected: got pulse, required none");
            end else begin
                e = sbq.pop_front();
                if (o_match_count !== e.cnt || o_frame_crc !== e.crc) begin
                    errors++;
                    $display("FAIL frame_result: got cnt=%0d crc=%h, required cnt=%0d crc=%h",
                             o_match_count, o_frame_crc, e.cnt, e.crc);
                end
            end
        end
    end

    task automatic pix(input logic h, input logic v, input logic [7:0] c);
        if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            stb = 1'b0;
            hs  = 1'($urandom_range(0, 1));
            vs  = 1'($urandom_range(0, 1));
            rgb = 8'($urandom);
        end
        @(negedge clk);
        stb = 1'b1;
        hs  = h;
        vs  = v;
        rgb = c;
        @(posedge clk);
        #1;
    endtask

    task automatic run_lines(input int mode, input int y0, input int y1,
                             input int short_line, input bit exp_stb,
                             input bit chk_probe);
        logic [18:0] cnt;
        logic [15:0] crc;
        logic [7:0]  c;
        logic        h, v;
        cnt = 19'd0;
        crc = 16'hFFFF;
        for (int y = y0; y <= y1; y++) begin
            for (int x = 0; x < HT; x++) begin
                if (y == short_line && x == HT - 1)
                    continue;
                c = pick(mode, x, y);
                h = !(x >= HSS && x < HSE);
                v = !(y >= VSS && y < VSE);
                if (x < HA && y < VA) begin
                    if (c == 8'hE0)
                        cnt = cnt + 19'd1;
                    crc = crc_ref(crc, c);
                end
                if (exp_stb && x == 0 && y == VSS) begin
`ifdef VGA_RX_CRC_EN
                    sbq.push_back('{cnt: cnt, crc: crc});
`else
                    sbq.push_back('{cnt: cnt, crc: 16'h0000});
`endif
                end
                pix(h, v, c);
                if (chk_probe && x == PX && y == PY) begin
                    checks++;
                    if (o_x !== 10'(PX) || o_y !== 9'(PY) || o_active !== 1'b1) begin
                        errors++;
                        $display("FAIL probe_pos: got x=%0d y=%0d act=%b, required x=%0d y=%0d act=1",
                                 o_x, o_y, o_active, PX, PY);
                    end
                    checks++;
                    if (o_probe_color !== 8'h1C) begin
                        errors++;
                        $display("FAIL probe_color: got %h, required 1c", o_probe_color);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        stb = 1'b0;
        hs  = 1'b1;
        vs  = 1'b1;
        rgb = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_x, o_y, o_active} !== 20'd0) begin
            errors++;
            $display("FAIL reset_pos: got x=%0d y=%0d act=%b, required 0 0 0", o_x, o_y, o_active);
        end
        checks++;
        if ({o_locked, o_frame_stb, o_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got lock=%b stb=%b err=%b, required 0 0 0",
                     o_locked, o_frame_stb, o_err);
        end
        checks++;
        if ({o_match_count, o_probe_color, o_frame_crc} !== 43'd0) begin
            errors++;
            $display("FAIL reset_data: got cnt=%0d probe=%h crc=%h, required 0 0 0",
                     o_match_count, o_probe_color, o_frame_crc);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock();
        run_lines(0, 0, VT - 1, -1, 1'b0, 1'b0);
        run_lines(0, 0, VT - 1, -1, 1'b0, 1'b0);
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL lock_early: got %b after one good frame, required 0", o_locked);
        end
        run_lines(0, 0, VT - 1, -1, 1'b0, 1'b0);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL lock_after_two: got %b, required 1", o_locked);
        end
        checks++;
        if (err_seen !== err_exp) begin
            errors++;
            $display("FAIL lock_no_err: got %0d err pulses, required %0d", err_seen, err_exp);
        end
    endtask

    task automatic test_match();
        run_lines(1, 0, VT - 1, -1, 1'b1, 1'b0);
        checks++;
        if (o_match_count !== 19'd100) begin
            errors++;
            $display("FAIL match_count: got %0d, required 100", o_match_count);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL match_stb_missing: got %0d pending, required 0", sbq.size());
        end
    endtask

    task automatic test_probe();
        run_lines(2, 0, VT - 1, -1, 1'b1, 1'b1);
        checks++;
        if (o_probe_color !== 8'h1C) begin
            errors++;
            $display("FAIL probe_hold: got %h, required 1c", o_probe_color);
        end
    endtask

    task automatic test_crc();
        logic [15:0] ref_crc;
        ref_crc = 16'hFFFF;
        for (int i = 0; i < HA * VA; i++)
            ref_crc = crc_ref(ref_crc, 8'h00);
`ifndef VGA_RX_CRC_EN
        ref_crc = 16'h0000;
`endif
        run_lines(0, 0, VT - 1, -1, 1'b1, 1'b0);
        checks++;
        if (o_frame_crc !== ref_crc) begin
            errors++;
            $display("FAIL crc_zero_frame: got %h, required %h", o_frame_crc, ref_crc);
        end
    endtask

    task automatic test_hold();
        logic [62:0] snap;
        snap = {o_x, o_y, o_active, o_locked, o_frame_stb, o_err,
                o_match_count, o_probe_color, o_frame_crc};
        repeat (40) begin
            @(negedge clk);
            stb = 1'b0;
            hs  = 1'($urandom_range(0, 1));
            vs  = 1'($urandom_range(0, 1));
            rgb = 8'($urandom);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({o_x, o_y, o_active, o_locked, o_frame_stb, o_err,
             o_match_count, o_probe_color, o_frame_crc} !== snap) begin
            errors++;
            $display("FAIL hold_no_strobe: got x=%0d y=%0d cnt=%0d lock=%b, required x=%0d y=%0d cnt=%0d lock=%b",
                     o_x, o_y, o_match_count, o_locked,
                     snap[62:53], snap[52:44], snap[42:24], snap[45]);
        end
    endtask

    task automatic test_error();
        run_lines(3, 0, VT - 1, 3, 1'b0, 1'b0);
        err_exp++;
        checks++;
        if (err_seen !== err_exp) begin
            errors++;
            $display("FAIL err_pulse: got %0d pulses, required %0d", err_seen, err_exp);
        end
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL err_unlock: got %b, required 0", o_locked);
        end
        run_lines(3, 0, VT - 1, -1, 1'b0, 1'b0);
        checks++;
        if (o_locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: got %b, required 0", o_locked);
        end
        run_lines(3, 0, VT - 1, -1, 1'b0, 1'b0);
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL relock: got %b, required 1", o_locked);
        end
        run_lines(3, 0, VT - 1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_lines(3, 0, 2, -1, 1'b0, 1'b0);
        for (int x = 0; x < 5; x++)
            pix(1'b1, 1'b1, pick(3, x, 3));
        checks++;
        if (o_locked !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_lock: got %b, required 1", o_locked);
        end
        @(negedge clk);
        rst = 1'b1;
        stb = 1'b1;
        hs  = 1'b1;
        vs  = 1'b1;
        rgb = 8'hE0;
        @(posedge clk);
        #1;
        checks++;
        if ({o_x, o_y, o_active, o_locked} !== 21'd0) begin
            errors++;
            $display("FAIL mid_reset_pos: got x=%0d y=%0d act=%b lock=%b, required 0 0 0 0",
                     o_x, o_y, o_active, o_locked);
        end
        checks++;
        if ({o_frame_stb, o_err} !== 2'b00) begin
            errors++;
            $display("FAIL mid_reset_pulse: got stb=%b err=%b, required 0 0", o_frame_stb, o_err);
        end
        checks++;
        if ({o_match_count, o_probe_color, o_frame_crc} !== 43'd0) begin
            errors++;
            $display("FAIL mid_reset_data: got cnt=%0d probe=%h crc=%h, required 0 0 0",
                     o_match_count, o_probe_color, o_frame_crc);
        end
        @(negedge clk);
        rst = 1'b0;
        stb = 1'b0;
        run_lines(3, 4, VT - 1, -1, 1'b0, 1'b0);
        checks++;
        if (err_seen !== err_exp || o_locked !== 1'b0) begin
            errors++;
            $display("FAIL mid_after: got err=%0d lock=%b, required err=%0d lock=0",
                     err_seen, o_locked, err_exp);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_match();
        test_probe();
        test_crc();
        test_hold();
        test_error();
        test_reset_mid();
        @(negedge clk);
        stb = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL frame_stb_missing: got %0d pending, required 0", sbq.size());
        end
        checks++;
        if (err_seen !== err_exp) begin
            errors++;
            $display("FAIL err_total: got %0d, required %0d", err_seen, err_exp);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
